// File: rtl/mem_io_bridge_if.sv
// Peripheral-side bus of the memory/IO bridge: one-hot channel select,
// request strobe, write data out, per-channel read data and acknowledges in.
interface mem_io_bridge_if #(
  parameter int N_IO = 4,
  parameter int IO_W = 24
);
  logic [N_IO-1:0]      io_sel;
  logic                 io_req;
  logic                 io_we;
  logic [IO_W-1:0]      io_wdata;
  logic [N_IO*IO_W-1:0] io_rdata;
  logic [N_IO-1:0]      io_ack;

  // Handshake: while io_req is high, io_sel/io_we/io_wdata are held stable;
  // the selected channel completes the transfer by raising its io_ack bit for
  // one cycle (with io_rdata valid on reads). Acks from unselected channels
  // are ignored.
  modport master (
    output io_sel, io_req, io_we, io_wdata,
    input  io_rdata, io_ack
  );

  modport slave (
    input  io_sel, io_req, io_we, io_wdata,
    output io_rdata, io_ack
  );
endinterface

// File: rtl/mem_io_bridge.sv
// Bridge between CPU datapath, data memory (zero-wait pass-through) and N
// memory-mapped IO channels (req/ack with CPU stall, timeout, sticky error).
module mem_io_bridge #(
  parameter int          DATA_W      = 32,
  parameter int          IO_W        = 24,
  parameter int          N_IO        = 4,
  parameter logic [31:0] IO_BASE     = 32'hFFFFFC00,
  parameter int          IO_WIN_BITS = 10,
  parameter int          IO_SEL_LSB  = 4,
  parameter int          TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mRead,
  input  logic              mWrite,
  input  logic              ioRead,
  input  logic              ioWrite,
  input  logic [31:0]       addr_in,
  input  logic [DATA_W-1:0] r_rdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [31:0]       addr_out,
  output logic              dmem_we,
  output logic [DATA_W-1:0] data_to_dmem,
  output logic [DATA_W-1:0] r_wdata,
  output logic              stall,
  input  logic              err_clr,
  output logic              io_err,
  output logic [1:0]        err_code,
  output logic [1:0]        dbg_state_o,
  mem_io_bridge_if.master   io
);
  localparam int SEL_W = $clog2(N_IO);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic              we_q, we_d;
  logic [IO_W-1:0]   wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;

  logic mem_any, io_any, io_access, conflict, in_win;
  logic new_err;
  logic [1:0] new_code;

  assign mem_any   = mRead | mWrite;
  assign io_any    = ioRead | ioWrite;
  assign io_access = io_any & ~mem_any;
  assign conflict  = io_any & mem_any;
  assign in_win    = addr_in[31:IO_WIN_BITS] == IO_BASE[31:IO_WIN_BITS];

  assign addr_out     = addr_in;
  assign dmem_we      = mWrite & ~io_any;
  assign data_to_dmem = mWrite ? r_rdata : '0;
  assign r_wdata      = mRead ? m_rdata : ((state_q == DONE) ? rd_buf_q : '0);
  // Held low during reset so a CPU already presenting an IO op is not frozen.
  assign stall        = rst_n & (((state_q == IDLE) & io_access) | (state_q == WAIT));

  // Peripheral outputs come only from registers.
  assign io.io_req   = (state_q == WAIT);
  assign io.io_sel   = (state_q == WAIT) ? (N_IO'(1) << ch_q) : '0;
  assign io.io_we    = (state_q == WAIT) & we_q;
  assign io.io_wdata = (state_q == WAIT) ? wdata_q : '0;

  assign io_err      = err_q;
  assign err_code    = code_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_buf_d = rd_buf_q;
    ch_d     = ch_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    new_err  = 1'b0;
    new_code = 2'b00;
    case (state_q)
      IDLE: begin
        if (conflict) begin
          new_err  = 1'b1;
          new_code = 2'b11;
        end else if (io_access && in_win) begin
          ch_d    = addr_in[IO_SEL_LSB +: SEL_W];
          we_d    = ioWrite;
          wdata_d = r_rdata[IO_W-1:0];
          cnt_d   = '0;
          state_d = WAIT;
        end else if (io_access) begin
          rd_buf_d = '0;
          new_err  = 1'b1;
          new_code = 2'b10;
          state_d  = DONE;
        end
      end
      WAIT: begin
        if (io.io_ack[ch_q]) begin
          rd_buf_d = we_q ? '0 : DATA_W'(io.io_rdata[ch_q*IO_W +: IO_W]);
          state_d  = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rd_buf_d = '0;
          new_err  = 1'b1;
          new_code = 2'b01;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // First error sticks; a clear coinciding with a new error keeps the new one.
    err_d  = err_q;
    code_d = code_q;
    if (new_err && (!err_q || err_clr)) begin
      err_d  = 1'b1;
      code_d = new_code;
    end else if (err_clr) begin
      err_d  = 1'b0;
      code_d = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_buf_q <= '0;
      ch_q     <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_buf_q <= rd_buf_d;
      ch_q     <= ch_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end
endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: memory pass-through, IO read/write,
// timeout, out-of-window, conflict, sticky error and reset abort.
module tb_mem_io_bridge;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mRead, mWrite, ioRead, ioWrite;
  logic [31:0] addr_in, r_rdata, m_rdata;
  logic [31:0] addr_out, data_to_dmem, r_wdata;
  logic        dmem_we, stall, err_clr, io_err;
  logic [1:0]  err_code, dbg_state;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int waits;

  always #5 clk = ~clk;

  mem_io_bridge_if #(.N_IO(4), .IO_W(24)) io_bus ();

  mem_io_bridge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mRead        (mRead),
    .mWrite       (mWrite),
    .ioRead       (ioRead),
    .ioWrite      (ioWrite),
    .addr_in      (addr_in),
    .r_rdata      (r_rdata),
    .m_rdata      (m_rdata),
    .addr_out     (addr_out),
    .dmem_we      (dmem_we),
    .data_to_dmem (data_to_dmem),
    .r_wdata      (r_wdata),
    .stall        (stall),
    .err_clr      (err_clr),
    .io_err       (io_err),
    .err_code     (err_code),
    .dbg_state_o  (dbg_state),
    .io           (io_bus.master)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst_n = 1'b0; mRead = 1'b0; mWrite = 1'b0; ioRead = 1'b1; ioWrite = 1'b0;
    addr_in = 32'h0; r_rdata = 32'h0; m_rdata = 32'h0; err_clr = 1'b0;
    io_bus.io_ack   = 4'b0000;
    io_bus.io_rdata = {24'h444444, 24'hABCDEF, 24'h222222, 24'h111111};

    // Reset with an IO read pending
    tick(); tick(); settle();
    check("rst_stall", stall, 0);
    check("rst_io_req", io_bus.io_req, 0);
    check("rst_io_sel", io_bus.io_sel, 0);
    check("rst_io_err", io_err, 0);
    check("rst_r_wdata", r_wdata, 0);
    check("rst_state", dbg_state, 0);

    // Memory write then read
    rst_n = 1'b1; ioRead = 1'b0; mWrite = 1'b1; addr_in = 32'h10; r_rdata = 32'hDEADBEEF;
    settle();
    check("mw_dmem_we", dmem_we, 1);
    check("mw_data", data_to_dmem, 32'hDEADBEEF);
    check("mw_addr", addr_out, 32'h10);
    check("mw_stall", stall, 0);
    tick();
    mWrite = 1'b0; mRead = 1'b1; m_rdata = 32'h12345678;
    settle();
    check("mr_r_wdata", r_wdata, 32'h12345678);
    check("mr_dmem_we", dmem_we, 0);
    check("mr_data_zero", data_to_dmem, 0);
    tick();

    // IO read from ch2, ack on 3rd WAIT cycle
    mRead = 1'b0; ioRead = 1'b1; addr_in = 32'hFFFFFC20; r_rdata = 32'h0;
    settle();
    check("ior_c0_stall", stall, 1);
    check("ior_c0_req", io_bus.io_req, 0);
    tick();
    io_bus.io_ack = 4'b0010;  // wrong channel must be ignored
    settle();
    check("ior_w1_sel", io_bus.io_sel, 4'b0100);
    check("ior_w1_we", io_bus.io_we, 0);
    check("ior_w1_req", io_bus.io_req, 1);
    check("ior_w1_stall", stall, 1);
    tick();
    io_bus.io_ack = 4'b0000;
    settle();
    check("ior_w2_stall", stall, 1);
    check("ior_w2_sel", io_bus.io_sel, 4'b0100);
    tick();
    io_bus.io_ack = 4'b0100;
    settle();
    check("ior_w3_stall", stall, 1);
    tick();
    io_bus.io_ack = 4'b0000;
    settle();
    check("ior_done_stall", stall, 0);
    check("ior_done_rdata", r_wdata, 32'h00ABCDEF);
    check("ior_done_req", io_bus.io_req, 0);
    check("ior_no_err", io_err, 0);
    tick();
    ioRead = 1'b0;
    settle();
    check("ior_idle_rdata", r_wdata, 0);
    tick();

    // IO write to ch1, ack on 1st WAIT cycle
    ioWrite = 1'b1; addr_in = 32'hFFFFFC10; r_rdata = 32'h11223344;
    settle();
    check("iow_c0_stall", stall, 1);
    check("iow_dmem_we", dmem_we, 0);
    tick();
    io_bus.io_ack = 4'b0010;
    settle();
    check("iow_wdata", io_bus.io_wdata, 24'h223344);
    check("iow_we", io_bus.io_we, 1);
    check("iow_sel", io_bus.io_sel, 4'b0010);
    check("iow_w1_stall", stall, 1);
    tick();
    io_bus.io_ack = 4'b0000;
    settle();
    check("iow_done_stall", stall, 0);
    check("iow_done_rdata", r_wdata, 0);
    tick();
    ioWrite = 1'b0;
    tick();

    // Timeout on ch3
    ioRead = 1'b1; addr_in = 32'hFFFFFC30;
    settle();
    check("to_c0_stall", stall, 1);
    tick();
    settle();
    waits = 0;
    while (io_bus.io_req === 1'b1 && waits < 20) begin
      waits++;
      tick();
      settle();
    end
    check("to_wait_cycles", waits, 15);
    check("to_done_stall", stall, 0);
    check("to_done_rdata", r_wdata, 0);
    check("to_io_err", io_err, 1);
    check("to_err_code", err_code, 2'b01);
    tick();
    ioRead = 1'b0;
    tick();

    // Out-of-window while error already held: code stays 01
    ioRead = 1'b1; addr_in = 32'h00001000;
    settle();
    check("oow1_stall", stall, 1);
    check("oow1_req", io_bus.io_req, 0);
    tick();
    settle();
    check("oow1_done_stall", stall, 0);
    check("oow1_keep_code", err_code, 2'b01);
    tick();
    ioRead = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    settle();
    check("clr1_io_err", io_err, 0);
    check("clr1_code", err_code, 2'b00);

    // Fresh out-of-window error
    ioRead = 1'b1; addr_in = 32'h00001000;
    settle();
    check("oow2_stall", stall, 1);
    tick();
    settle();
    check("oow2_req", io_bus.io_req, 0);
    check("oow2_stall_done", stall, 0);
    check("oow2_code", err_code, 2'b10);
    check("oow2_io_err", io_err, 1);
    tick();
    ioRead = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    settle();
    check("clr2_code", err_code, 2'b00);

    // Memory/IO conflict: memory wins
    mRead = 1'b1; ioRead = 1'b1; addr_in = 32'hFFFFFC20; m_rdata = 32'hCAFEF00D;
    settle();
    check("cf_r_wdata", r_wdata, 32'hCAFEF00D);
    check("cf_stall", stall, 0);
    check("cf_req", io_bus.io_req, 0);
    tick();
    settle();
    check("cf_code", err_code, 2'b11);
    check("cf_io_err", io_err, 1);
    check("cf_req_after", io_bus.io_req, 0);
    // Clear coinciding with a new error records the new error
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0; mRead = 1'b0; ioRead = 1'b0;
    settle();
    check("cf_clr_same_err", io_err, 1);
    check("cf_clr_same_code", err_code, 2'b11);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Reset mid-transaction aborts without error
    ioRead = 1'b1; addr_in = 32'hFFFFFC00;
    tick();
    settle();
    check("rm_req", io_bus.io_req, 1);
    check("rm_sel", io_bus.io_sel, 4'b0001);
    rst_n = 1'b0;
    tick();
    settle();
    check("rm_req_after", io_bus.io_req, 0);
    check("rm_stall_after", stall, 0);
    check("rm_io_err", io_err, 0);
    rst_n = 1'b1; ioRead = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
Parametrised memory/IO bridge between the CPU datapath and both data memory and N memory-mapped IO channels. The memory path is pass-through and zero-wait. IO accesses are decoded to one channel and run through a req/ack handshake with a stall to the CPU and a timeout. Address, protocol and timeout errors are recorded in a sticky register. It sits between the ALU/controller and the dmem and IO peripherals (LED, switch, segment, ...).

Parameters:
DATA_W, 32, register/memory data width
IO_W, 24, IO data width; must be ≤ DATA_W
N_IO, 4, number of IO channels (power of 2, ≥2)
IO_BASE, 32'hFFFFFC00, base of IO window (aligned to window size)
IO_WIN_BITS, 10, log2 of IO window size in bytes
IO_SEL_LSB, 4, lowest address bit of channel index; index = addr_in[IO_SEL_LSB +: log2(N_IO)]
TIMEOUT, 15, maximum cycles in WAIT before abort (≥1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
mRead  in  1  memory read, from controller
mWrite  in  1  memory write, from controller
ioRead  in  1  IO read, from controller
ioWrite  in  1  IO write, from controller
addr_in  in  32  address from ALU result
r_rdata  in  DATA_W  store data from register file
m_rdata  in  DATA_W  data read from dmem
addr_out  out  32  address to dmem (= addr_in)
dmem_we  out  1  dmem write enable
data_to_dmem  out  DATA_W  store data to dmem
r_wdata  out  DATA_W  load data to register file
stall  out  1  CPU hold; CPU keeps all inputs stable while high
io_sel  out  N_IO  one-hot channel select
io_req  out  1  IO request strobe
io_we  out  1  IO write (1) / read (0)
io_wdata  out  IO_W  IO write data
io_rdata  in  N_IO*IO_W  channel read data, channel k at [k*IO_W +: IO_W]
io_ack  in  N_IO  per-channel acknowledge
err_clr  in  1  clears sticky error
io_err  out  1  sticky error flag
err_code  out  2  01 timeout, 10 out-of-window, 11 mem/IO conflict

Behaviour:
- Reset (rst_n low at an edge): state=IDLE, cnt=0, rd_buf=0, latched ch/we/wdata=0, io_err=0, err_code=0. Combinational outputs then give io_req=0, io_sel=0, stall=0.
- Reset mid-transaction aborts it. io_req drops after the reset edge, and no error is recorded.
- Memory path is combinational:
  - addr_out=addr_in.
  - dmem_we=mWrite & ~(ioRead|ioWrite).
  - data_to_dmem=r_rdata when mWrite, else 0. No Z outputs.
- r_wdata:
  - mRead: m_rdata.
  - else in DONE: rd_buf.
  - else 0.
- Conflict: mRead|mWrite together with ioRead|ioWrite means memory wins and the IO request is ignored. If io_err=0, set io_err=1 and err_code=11.
- io_access = (ioRead|ioWrite) & ~(mRead|mWrite). in_win = addr_in[31:IO_WIN_BITS]==IO_BASE[31:IO_WIN_BITS].
- FSM states IDLE, WAIT, DONE:
  - IDLE:
    - io_access & in_win: latch ch, we=ioWrite, wdata=r_rdata[IO_W-1:0]; cnt=0; go to WAIT. stall=1 this cycle.
    - io_access & ~in_win: no channel touched. rd_buf=0, record err 10, go to DONE. stall=1 this cycle.
    - Otherwise stall=0.
  - WAIT:
    - stall=1, io_req=1, io_sel=1<<ch, io_we/io_wdata from latches.
    - io_ack[ch]=1: rd_buf = zero-extended io_rdata[ch] (reads) or 0 (writes); go to DONE.
    - Else if cnt==TIMEOUT-1: rd_buf=0, record err 01, go to DONE.
    - Else cnt++.
    - io_ack on other channels is ignored.
  - DONE: stall=0 and r_wdata=rd_buf. The CPU completes the instruction whose inputs are still present. The bridge ignores the inputs and returns to IDLE.
- Latency: IO request at cycle 0; ack sampled at cycle k (k≥1, in WAIT); DONE at k+1. Stall lasts k+1 cycles.
- Error register: the first error wins. Later errors do not overwrite while io_err=1.
  - err_clr clears io_err and err_code next edge.
  - err_clr in the same cycle as a new error: the new error is recorded.
- io_* outputs depend only on registered state (glitch-free to peripherals).

Test Plan:
- Reset: rst_n=0 for 2 cycles with ioRead=1 → stall=0, io_req=0, io_sel=0, io_err=0, r_wdata=0.
- Memory: mWrite=1, addr_in=0x10, r_rdata=0xDEADBEEF → dmem_we=1, data_to_dmem=0xDEADBEEF, addr_out=0x10, stall=0. Then mRead=1, m_rdata=0x12345678 → r_wdata=0x12345678 same cycle.
- IO read: ioRead=1, addr_in=0xFFFFFC20; ch2 acks on the 3rd WAIT cycle with data 0xABCDEF.
  - io_sel=4'b0100 and io_we=0 during WAIT.
  - stall high 4 cycles.
  - DONE cycle: r_wdata=0x00ABCDEF, stall=0.
- IO write: ioWrite=1, addr_in=0xFFFFFC10, r_rdata=0x11223344; ch1 acks on the 1st WAIT cycle → io_wdata=0x223344, io_we=1, io_sel=4'b0010, stall high 2 cycles.
- Timeout: ioRead to 0xFFFFFC30 with no ack → WAIT exactly 15 cycles, then DONE with r_wdata=0, io_err=1, err_code=01. A later out-of-window error does not change err_code. err_clr → io_err=0, err_code=00.
- Out-of-window/conflict:
  - ioRead at 0x00001000 → io_req never asserted, stall 1 cycle, err_code=10.
  - After err_clr: mRead+ioRead together → r_wdata=m_rdata, io_req=0, err_code=11.
